// File: rtl/safe_lock_sequencer_if.sv
// rtl/safe_lock_sequencer_if.sv - code verdict inputs and bolt/indicator outputs of the safe lock sequencer
interface safe_lock_sequencer_if;
  logic       code_ok;
  logic       code_bad;
  logic       relock;
  logic       unlock;
  logic       lockout;
  logic [3:0] fail_cnt;
  logic [7:0] sec_left;
  logic       sec_tick;

  modport master (
    output code_ok, code_bad, relock,
    input  unlock, lockout, fail_cnt, sec_left, sec_tick
  );

  modport slave (
    input  code_ok, code_bad, relock,
    output unlock, lockout, fail_cnt, sec_left, sec_tick
  );
endinterface

// File: rtl/safe_lock_sequencer.sv
// rtl/safe_lock_sequencer.sv - failure counter plus timed door-open / lockout phases on a shared second prescaler
module safe_lock_sequencer #(
  parameter int TICK_DIV = 50000000,
  parameter int MAX_FAIL = 3,
  parameter int OPEN_SEC = 10,
  parameter int LOCK_SEC = 30
) (
  input  logic                  clk,
  input  logic                  rst,
  safe_lock_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OPEN    = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_e;

  localparam int               CNT_W      = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TICK_DIV - 1);
  localparam logic [3:0]       FAIL_LIMIT = 4'(MAX_FAIL);
  localparam logic [7:0]       OPEN_LOAD  = 8'(OPEN_SEC);
  localparam logic [7:0]       LOCK_LOAD  = 8'(LOCK_SEC);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       fail_q, fail_d;
  logic [7:0]       sec_q, sec_d;
  logic             tick_q, tick_d;
  logic             unlock_q, unlock_d;
  logic             lockout_q, lockout_d;

  logic timed;
  logic sec_edge;
  logic last_sec;
  logic bad_hits_limit;

  assign timed          = (state_q != ST_IDLE);
  assign sec_edge       = timed && (cnt_q == CNT_LAST);
  assign last_sec       = (sec_q == 8'd1);
  assign bad_hits_limit = ((fail_q + 4'd1) == FAIL_LIMIT);

  always_comb begin
    state_d = state_q;
    fail_d  = fail_q;
    sec_d   = sec_q;
    tick_d  = 1'b0;
    cnt_d   = '0;

    // Prescaler runs only inside a timed phase and wraps on the second boundary.
    if (timed && !sec_edge) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.code_bad) begin
          if (bad_hits_limit) begin
            state_d = ST_LOCKOUT;
            fail_d  = 4'd0;
            sec_d   = LOCK_LOAD;
          end else begin
            fail_d = fail_q + 4'd1;
          end
        end else if (bus.code_ok) begin
          state_d = ST_OPEN;
          fail_d  = 4'd0;
          sec_d   = OPEN_LOAD;
        end
      end

      ST_OPEN: begin
        if (bus.relock) begin
          state_d = ST_IDLE;
          sec_d   = 8'd0;
          cnt_d   = '0;
        end else if (sec_edge) begin
          tick_d = 1'b1;
          if (last_sec) begin
            state_d = ST_IDLE;
            sec_d   = 8'd0;
          end else begin
            sec_d = sec_q - 8'd1;
          end
        end
      end

      ST_LOCKOUT: begin
        if (sec_edge) begin
          tick_d = 1'b1;
          if (last_sec) begin
            state_d = ST_IDLE;
            sec_d   = 8'd0;
          end else begin
            sec_d = sec_q - 8'd1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        fail_d  = 4'd0;
        sec_d   = 8'd0;
        cnt_d   = '0;
      end
    endcase

    unlock_d  = (state_d == ST_OPEN);
    lockout_d = (state_d == ST_LOCKOUT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      fail_q    <= 4'd0;
      sec_q     <= 8'd0;
      tick_q    <= 1'b0;
      unlock_q  <= 1'b0;
      lockout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fail_q    <= fail_d;
      sec_q     <= sec_d;
      tick_q    <= tick_d;
      unlock_q  <= unlock_d;
      lockout_q <= lockout_d;
    end
  end

  assign bus.unlock   = unlock_q;
  assign bus.lockout  = lockout_q;
  assign bus.fail_cnt = fail_q;
  assign bus.sec_left = sec_q;
  assign bus.sec_tick = tick_q;

endmodule

// File: tb/tb_safe_lock_sequencer.sv
// tb/tb_safe_lock_sequencer.sv - scoreboard bench for safe_lock_sequencer with TICK_DIV=4 MAX_FAIL=3 OPEN_SEC=2 LOCK_SEC=3
module tb_safe_lock_sequencer;

  localparam int TD = 4;

  localparam logic [2:0] S_NONE = 3'b000;
  localparam logic [2:0] S_OK   = 3'b100;
  localparam logic [2:0] S_BAD  = 3'b010;
  localparam logic [2:0] S_RL   = 3'b001;

  typedef struct {
    string       name;
    logic [14:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  exp_t       sb[$];
  logic [2:0] stim[$];

  safe_lock_sequencer_if bus ();

  safe_lock_sequencer #(
    .TICK_DIV (4),
    .MAX_FAIL (3),
    .OPEN_SEC (2),
    .LOCK_SEC (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Packed order: unlock, lockout, fail_cnt, sec_left, sec_tick
  function automatic logic [14:0] pack(input logic u, input logic l, input logic [3:0] f,
                                       input logic [7:0] s, input logic t);
    return {u, l, f, s, t};
  endfunction

  function automatic logic [14:0] obs();
    return {bus.unlock, bus.lockout, bus.fail_cnt, bus.sec_left, bus.sec_tick};
  endfunction

  function automatic void push(input string name, input logic [14:0] v);
    exp_t e;
    e.name = name;
    e.v    = v;
    sb.push_back(e);
  endfunction

  function automatic void stims(input logic [2:0] s, input int n);
    for (int i = 0; i < n; i++) stim.push_back(s);
  endfunction

  // Expected view after each edge k of a timed phase, k=0 being the entering edge.
  function automatic void push_phase(input string name, input bit is_open, input int secs, input int last_k);
    int  s;
    logic t;
    for (int k = 0; k <= last_k; k++) begin
      s = secs - k / TD;
      t = (k > 0) && (k % TD == 0);
      push($sformatf("%s[%0d]", name, k),
           pack(is_open && s != 0, !is_open && s != 0, 4'd0, 8'(s), t));
    end
  endfunction

  task automatic drive(input logic [2:0] s);
    bus.code_ok  = s[2];
    bus.code_bad = s[1];
    bus.relock   = s[0];
    @(posedge clk);
    #1;
    bus.code_ok  = 1'b0;
    bus.code_bad = 1'b0;
    bus.relock   = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    #2 rst = 1'b1;
    #1;
    push("reset_async", 15'd0);
    e = sb.pop_front();
    n_checks++;
    if (obs() !== e.v) begin
      n_errors++;
      $display("FAIL %s: observed %h required %h", e.name, obs(), e.v);
    end
    @(posedge clk);
    #1;
    push("reset_held", 15'd0);
    e = sb.pop_front();
    n_checks++;
    if (obs() !== e.v) begin
      n_errors++;
      $display("FAIL %s: observed %h required %h", e.name, obs(), e.v);
    end
    #3 rst = 1'b0;
  endtask

  task automatic test_open_timeout();
    exp_t e;
    stims(S_OK, 1);
    stims(S_NONE, 7);
    stims(S_BAD, 1);
    push_phase("open_timeout", 1'b1, 2, 2 * TD);
    stims(S_NONE, 1);
    push("open_then_idle", 15'd0);
    while (stim.size() > 0) begin
      drive(stim.pop_front());
      e = sb.pop_front();
      n_checks++;
      if (obs() !== e.v) begin
        n_errors++;
        $display("FAIL %s: observed %h required %h", e.name, obs(), e.v);
      end
    end
  endtask

  task automatic test_fail_then_ok();
    exp_t e;
    stims(S_BAD, 1);  push("fail_1", pack(0, 0, 4'd1, 8'd0, 0));
    stims(S_BAD, 1);  push("fail_2", pack(0, 0, 4'd2, 8'd0, 0));
    stims(S_OK, 1);
    stims(S_NONE, 2 * TD);
    push_phase("fail_then_open", 1'b1, 2, 2 * TD);
    stims(S_NONE, 1); push("fail_then_idle", 15'd0);
    while (stim.size() > 0) begin
      drive(stim.pop_front());
      e = sb.pop_front();
      n_checks++;
      if (obs() !== e.v) begin
        n_errors++;
        $display("FAIL %s: observed %h required %h", e.name, obs(), e.v);
      end
    end
  endtask

  task automatic test_lockout();
    exp_t e;
    stims(S_BAD, 1);  push("lk_fail_1", pack(0, 0, 4'd1, 8'd0, 0));
    stims(S_BAD, 1);  push("lk_fail_2", pack(0, 0, 4'd2, 8'd0, 0));
    stims(S_BAD, 1);
    stims(S_NONE, 3 * TD);
    push_phase("lockout", 1'b0, 3, 3 * TD);
    stim[3] = S_OK;
    stim[5] = S_RL;
    stim[7] = S_BAD;
    stim[9] = S_OK | S_BAD;
    stims(S_OK, 1);   push("lk_first_idle_ok", pack(1, 0, 4'd0, 8'd2, 0));
    stims(S_RL, 1);   push("lk_relock", 15'd0);
    while (stim.size() > 0) begin
      drive(stim.pop_front());
      e = sb.pop_front();
      n_checks++;
      if (obs() !== e.v) begin
        n_errors++;
        $display("FAIL %s: observed %h required %h", e.name, obs(), e.v);
      end
    end
  endtask

  task automatic test_relock();
    exp_t e;
    stims(S_OK, 1);   push("rl_open", pack(1, 0, 4'd0, 8'd2, 0));
    stims(S_NONE, 1); push("rl_open_hold", pack(1, 0, 4'd0, 8'd2, 0));
    stims(S_RL, 1);   push("rl_closed", 15'd0);
    stims(S_RL, 1);   push("rl_idle_ignored", 15'd0);
    stims(S_OK, 1);
    stims(S_NONE, 2 * TD);
    push_phase("rl_reopen", 1'b1, 2, 2 * TD);
    stims(S_NONE, 1); push("rl_reopen_idle", 15'd0);
    while (stim.size() > 0) begin
      drive(stim.pop_front());
      e = sb.pop_front();
      n_checks++;
      if (obs() !== e.v) begin
        n_errors++;
        $display("FAIL %s: observed %h required %h", e.name, obs(), e.v);
      end
    end
  endtask

  task automatic test_bad_ok_same();
    exp_t e;
    stims(S_BAD, 1);  push("both_fail_1", pack(0, 0, 4'd1, 8'd0, 0));
    stims(S_BAD, 1);  push("both_fail_2", pack(0, 0, 4'd2, 8'd0, 0));
    stims(S_OK | S_BAD, 1);
    stims(S_NONE, 3 * TD);
    push_phase("both_lockout", 1'b0, 3, 3 * TD);
    stims(S_NONE, 1); push("both_idle", 15'd0);
    while (stim.size() > 0) begin
      drive(stim.pop_front());
      e = sb.pop_front();
      n_checks++;
      if (obs() !== e.v) begin
        n_errors++;
        $display("FAIL %s: observed %h required %h", e.name, obs(), e.v);
      end
    end
  endtask

  task automatic test_reset_mid_lockout();
    exp_t e;
    stims(S_BAD, 1);  push("mid_fail_1", pack(0, 0, 4'd1, 8'd0, 0));
    stims(S_BAD, 1);  push("mid_fail_2", pack(0, 0, 4'd2, 8'd0, 0));
    stims(S_BAD, 1);
    stims(S_NONE, TD);
    push_phase("mid_lockout", 1'b0, 3, TD);
    while (stim.size() > 0) begin
      drive(stim.pop_front());
      e = sb.pop_front();
      n_checks++;
      if (obs() !== e.v) begin
        n_errors++;
        $display("FAIL %s: observed %h required %h", e.name, obs(), e.v);
      end
    end
    rst = 1'b1;
    #2;
    push("mid_rst_immediate", 15'd0);
    e = sb.pop_front();
    n_checks++;
    if (obs() !== e.v) begin
      n_errors++;
      $display("FAIL %s: observed %h required %h", e.name, obs(), e.v);
    end
    #2 rst = 1'b0;
    stims(S_OK, 1);
    stims(S_NONE, 2 * TD);
    push_phase("mid_after_rst_open", 1'b1, 2, 2 * TD);
    stims(S_BAD, 1);  push("mid_no_residual_fail", pack(0, 0, 4'd1, 8'd0, 0));
    while (stim.size() > 0) begin
      drive(stim.pop_front());
      e = sb.pop_front();
      n_checks++;
      if (obs() !== e.v) begin
        n_errors++;
        $display("FAIL %s: observed %h required %h", e.name, obs(), e.v);
      end
    end
  endtask

  initial begin
    bus.code_ok  = 1'b0;
    bus.code_bad = 1'b0;
    bus.relock   = 1'b0;
    test_reset();
    test_open_timeout();
    test_fail_then_ok();
    test_lockout();
    test_relock();
    test_bad_ok_same();
    test_reset_mid_lockout();
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: observed %0d entries left required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed no completion required finish before 50000");
    $fatal(1);
  end

endmodule
